mseq_enc: RTL and testbench
===========================

Name: mseq_enc

Overview:
Spreading transmitter for the M-sequence link: serialises a parallel data word into a chip stream that the `dec` correlator despreads.
- Each data bit becomes one symbol: N_CHIP chips of TEMPLATE (bit=1) or its bitwise inverse (bit=0), followed by GAP idle chips at 0.
- Sits at the transmit end of the link, driving the single-bit `signal` line into `dec`.

Parameters:
TEMPLATE, 31'b0110100110100110100101001101001, spreading code; chip k of a symbol is TEMPLATE[k], k=0 first
N_CHIP, 31, chips per symbol (TEMPLATE width)
GAP, 1, idle chips (value 0) after each symbol; 0 allowed
N_BITS, 8, data word width
MSB_FIRST, 1, 1: bit N_BITS-1 sent first; 0: bit 0 sent first

Ports:
clk  input  1  chip clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
data  input  N_BITS  word to transmit
data_valid  input  1  request; word accepted when data_valid && data_ready on a rising edge
data_ready  output  1  encoder idle, can accept a word
signal  output  1  registered chip output
sym_start  output  1  registered pulse, high during chip 0 of every symbol
busy  output  1  high from the first chip of a word through its last gap chip
done  output  1  one-cycle pulse in the cycle after the word's last chip/gap chip
chip_cnt  output  8  index of the chip currently on signal: 0..N_CHIP+GAP-1; 0 when idle

Behaviour:
- Reset (async assert, sync release): state IDLE; signal=0, sym_start=0, busy=0, done=0, chip_cnt=0, data_ready=1; shift register and bit counter cleared.
- States:
  - IDLE: data_ready=1, signal=0. On accept, latch data; go to SYM with bit pointer at the first bit per MSB_FIRST.
  - SYM: signal = TEMPLATE[chip_cnt] XNOR current bit, for chip_cnt=0..N_CHIP-1. sym_start=1 when chip_cnt=0.
  - GAP: signal=0 for GAP cycles; chip_cnt continues N_CHIP..N_CHIP+GAP-1. If GAP=0, GAP is skipped.
  - After the last chip of a symbol, or its last gap chip: if bits remain, advance the bit pointer and return to SYM with chip_cnt=0. Otherwise go to IDLE, and done=1 for that one IDLE cycle.
- Latency: the first chip appears on signal in the cycle following the accepting edge.
- Word period: N_BITS*(N_CHIP+GAP) cycles (256 at defaults). No idle cycles between symbols of one word.
- data_ready is 0 from the accept edge until return to IDLE. data_valid and data changes while busy are ignored; the latched word is immune to them.
- Back-to-back: in the done cycle data_ready=1, so a word held valid is accepted there. The next word's chip 0 follows, giving exactly one idle 0 chip between words.
- chip_cnt is a registered 8-bit counter; it wraps to 0 at N_CHIP+GAP-1, never exceeding it.
- Reset asserted mid-word: outputs go to reset values immediately; the word is discarded, not resumed.
- Constraints: TEMPLATE width must equal N_CHIP; N_CHIP+GAP ≤ 256.

Test Plan:
- Reset, then data=8'hFF with data_valid pulsed 1 cycle -> 8 symbols. In each symbol, signal on chip_cnt 0..30 equals TEMPLATE[0..30] and is 0 at chip_cnt 31. sym_start is high every 32 cycles; done fires 256 cycles after the first chip.
- data=8'h00 -> every symbol is ~TEMPLATE followed by one 0 chip. Feeding signal into `dec` gives `dec`.buff_wr == ~TEMPLATE after the first symbol.
- data=8'hA5, MSB_FIRST=1 -> symbol polarity sequence T,~T,T,~T,~T,T,~T,T. With MSB_FIRST=0 -> T,~T,T,~T,~T,T,~T,T reversed bit order (bit 0 first: 1,0,1,0,0,1,0,1).
- data_valid held high with data changing during transmission -> only the first word is sent. data_ready stays 0 until the done cycle; the next word is accepted in the done cycle with exactly one idle 0 chip between words.
- rst_n pulled low at chip 15 of symbol 3 -> signal, busy and chip_cnt are 0 in the same cycle (asynchronous), without waiting for a clock edge. After release, a new word 8'h81 transmits correctly from chip 0.
- Loopback with `dec` (data=8'hFF): `dec`.buff_wr == TEMPLATE is reached within the first 32 cycles after the first chip.

Source files
------------

// File: rtl/mseq_enc.sv
// M-sequence spreading transmitter: each bit of a latched word is sent as N_CHIP
// chips of TEMPLATE (bit=1) or ~TEMPLATE (bit=0), then GAP idle zero chips.
module mseq_enc #(
    parameter int unsigned       N_CHIP    = 31,
    parameter logic [N_CHIP-1:0] TEMPLATE  = 31'b0110100110100110100101001101001,
    parameter int unsigned       GAP       = 1,
    parameter int unsigned       N_BITS    = 8,
    parameter bit                MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_BITS-1:0] data,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              signal,
    output logic              sym_start,
    output logic              busy,
    output logic              done,
    output logic [7:0]        chip_cnt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SYM  = 2'd1;
    localparam logic [1:0] GAPS = 2'd2;

    localparam int BW = (N_BITS > 1) ? $clog2(N_BITS) : 1;

    // Template widened to the full 8-bit chip index range so chip_cnt indexes it directly.
    localparam logic [255:0]   TMPL_EXT  = 256'(TEMPLATE);
    localparam logic [7:0]     LAST_CHIP = 8'(N_CHIP - 1);
    localparam logic [7:0]     LAST_SLOT = 8'(N_CHIP + GAP - 1);
    localparam logic [7:0]     GAP_FIRST = 8'(N_CHIP);
    localparam logic [BW-1:0]  LAST_BIT  = BW'(N_BITS - 1);

    logic [1:0]        state_q, state_d;
    logic [7:0]        chip_q, chip_d;
    logic [N_BITS-1:0] shreg_q, shreg_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic              signal_q, signal_d;
    logic              sym_q, sym_d;
    logic              done_q, done_d;

    logic [7:0]        chip_inc;
    logic [N_BITS-1:0] shreg_adv;
    logic              cur_bit;
    logic              sym_end;

    // The bit on air is always at the head of the shift register.
    function automatic logic head(input logic [N_BITS-1:0] v);
        return MSB_FIRST ? v[N_BITS-1] : v[0];
    endfunction

    assign chip_inc  = chip_q + 8'd1;
    assign shreg_adv = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
    assign cur_bit   = head(shreg_q);

    always_comb begin
        state_d  = state_q;
        chip_d   = chip_q;
        shreg_d  = shreg_q;
        bit_d    = bit_q;
        signal_d = 1'b0;
        sym_d    = 1'b0;
        done_d   = 1'b0;
        sym_end  = 1'b0;

        case (state_q)
            IDLE: begin
                chip_d = 8'd0;
                if (data_valid) begin
                    state_d  = SYM;
                    shreg_d  = data;
                    bit_d    = '0;
                    signal_d = TMPL_EXT[0] ~^ head(data);
                    sym_d    = 1'b1;
                end
            end
            SYM: begin
                if (chip_q != LAST_CHIP) begin
                    chip_d   = chip_inc;
                    signal_d = TMPL_EXT[chip_inc] ~^ cur_bit;
                end else if (GAP > 0) begin
                    state_d = GAPS;
                    chip_d  = GAP_FIRST;
                end else begin
                    sym_end = 1'b1;
                end
            end
            GAPS: begin
                if (chip_q != LAST_SLOT) chip_d = chip_inc;
                else                     sym_end = 1'b1;
            end
            default: begin
                state_d = IDLE;
                chip_d  = 8'd0;
            end
        endcase

        // Symbol boundary: start the next bit with no idle cycle, or finish the word.
        if (sym_end) begin
            if (bit_q != LAST_BIT) begin
                state_d  = SYM;
                chip_d   = 8'd0;
                bit_d    = bit_q + 1'b1;
                shreg_d  = shreg_adv;
                signal_d = TMPL_EXT[0] ~^ head(shreg_adv);
                sym_d    = 1'b1;
            end else begin
                state_d = IDLE;
                chip_d  = 8'd0;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            chip_q   <= 8'd0;
            shreg_q  <= '0;
            bit_q    <= '0;
            signal_q <= 1'b0;
            sym_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            chip_q   <= chip_d;
            shreg_q  <= shreg_d;
            bit_q    <= bit_d;
            signal_q <= signal_d;
            sym_q    <= sym_d;
            done_q   <= done_d;
        end
    end

    assign data_ready = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign signal     = signal_q;
    assign sym_start  = sym_q;
    assign done       = done_q;
    assign chip_cnt   = chip_q;

endmodule

// File: tb/tb_mseq_enc.sv
// Directed bench for mseq_enc: an MSB-first default instance and an LSB-first
// instance, checked chip by chip against a template model.
module tb_mseq_enc;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_m = 8'h00, data_l = 8'h00;
    logic       dv_m = 1'b0, dv_l = 1'b0;
    logic       rdy_m, sig_m, sym_m, busy_m, done_m;
    logic       rdy_l, sig_l, sym_l, busy_l, done_l;
    logic [7:0] cnt_m, cnt_l;
    logic       sel = 1'b0;

    logic [30:0] tmpl = 31'b0110100110100110100101001101001;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mseq_enc dut_m (
        .clk(clk), .rst_n(rst_n), .data(data_m), .data_valid(dv_m),
        .data_ready(rdy_m), .signal(sig_m), .sym_start(sym_m), .busy(busy_m),
        .done(done_m), .chip_cnt(cnt_m)
    );

    mseq_enc #(.MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .data(data_l), .data_valid(dv_l),
        .data_ready(rdy_l), .signal(sig_l), .sym_start(sym_l), .busy(busy_l),
        .done(done_l), .chip_cnt(cnt_l)
    );

    wire       o_rdy  = sel ? rdy_l  : rdy_m;
    wire       o_sig  = sel ? sig_l  : sig_m;
    wire       o_sym  = sel ? sym_l  : sym_m;
    wire       o_busy = sel ? busy_l : busy_m;
    wire       o_done = sel ? done_l : done_m;
    wire [7:0] o_cnt  = sel ? cnt_l  : cnt_m;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".sig"},  8'(o_sig),  8'd0);
        chk({tag, ".busy"}, 8'(o_busy), 8'd0);
        chk({tag, ".cnt"},  o_cnt,      8'd0);
        chk({tag, ".rdy"},  8'(o_rdy),  8'd1);
        chk({tag, ".sym"},  8'(o_sym),  8'd0);
    endtask

    // Entered in the cycle showing chip 0; returns in the done cycle.
    task automatic run_word(input logic [7:0] w, input bit msb, input bit chg);
        logic [4:0] k;
        logic [2:0] s, bidx;
        logic       b, e;
        for (int i = 0; i < 256; i++) begin
            k    = 5'(i % 32);
            s    = 3'(i / 32);
            bidx = msb ? (3'd7 - s) : s;
            b    = w[bidx];
            e    = (k != 5'd31) ? (tmpl[k] ~^ b) : 1'b0;
            chk("sig",  8'(o_sig),  8'(e));
            chk("cnt",  o_cnt,      {3'b0, k});
            chk("sym",  8'(o_sym),  8'(k == 5'd0));
            chk("busy", 8'(o_busy), 8'd1);
            chk("rdy",  8'(o_rdy),  8'd0);
            chk("done", 8'(o_done), 8'd0);
            if (chg && i == 100) data_m = 8'h3C;
            tick();
        end
        chk("end.done", 8'(o_done), 8'd1);
        chk_idle("end");
    endtask

    initial begin
        // Reset state
        #12;
        chk_idle("rst");
        chk("rst.done", 8'(done_m), 8'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk_idle("post_rst");

        // 8'hFF, valid pulsed one cycle
        data_m = 8'hFF; dv_m = 1'b1;
        tick();
        dv_m = 1'b0;
        run_word(8'hFF, 1'b1, 1'b0);
        tick();
        chk("done_pulse", 8'(done_m), 8'd0);
        chk_idle("after_ff");

        // 8'h00: every symbol inverted
        data_m = 8'h00; dv_m = 1'b1;
        tick();
        dv_m = 1'b0;
        run_word(8'h00, 1'b1, 1'b0);
        tick();

        // Held valid, data changed mid-word, back-to-back accept in done cycle
        data_m = 8'hA5; dv_m = 1'b1;
        tick();
        run_word(8'hA5, 1'b1, 1'b1);
        tick();
        dv_m = 1'b0;
        run_word(8'h3C, 1'b1, 1'b0);
        tick();
        chk_idle("after_b2b");

        // LSB-first instance
        sel = 1'b1;
        data_l = 8'h0F; dv_l = 1'b1;
        tick();
        dv_l = 1'b0;
        data_l = 8'hF0;
        run_word(8'h0F, 1'b0, 1'b0);
        tick();
        sel = 1'b0;

        // Async reset at chip 15 of symbol 3
        data_m = 8'h5A; dv_m = 1'b1;
        tick();
        dv_m = 1'b0;
        for (int i = 0; i < 111; i++) tick();
        chk("pre_rst.cnt",  cnt_m,       8'd15);
        chk("pre_rst.busy", 8'(busy_m),  8'd1);
        rst_n = 1'b0;
        #1;
        chk_idle("async_rst");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk_idle("rst_release");
        data_m = 8'h81; dv_m = 1'b1;
        tick();
        dv_m = 1'b0;
        run_word(8'h81, 1'b1, 1'b0);
        tick();
        chk_idle("final");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
